// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: sends an 11-bit {cmd[9], cmd} frame under SS_n/SCLK and,
// for opcode 11, clocks a byte back on MISO. All outputs are registered.
module spi_cmd_master #(
  parameter int CLK_DIV = 2,
  parameter int RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] cmd,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic [2:0] dbg_state_o
);

  // Handshake: start is a request sampled only in IDLE (accepted on that edge, busy rises);
  // done is a one-cycle acknowledge with busy already low, so start may be re-asserted there.
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_RDWAIT, S_RDSHIFT, S_FINISH} state_e;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [3:0]    WAIT_LAST = 4'(RD_WAIT - 1);

  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [3:0]     bit_q, bit_d;
  logic           sclk_q, sclk_d;
  logic           ss_n_q, ss_n_d;
  logic           mosi_q, mosi_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           rd_valid_q, rd_valid_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic [7:0]     shift_q, shift_d;
  logic [10:0]    frame_q, frame_d;

  logic tick, bit_end, last_bit, is_read;
  assign tick     = (div_q == DIV_LAST);
  assign bit_end  = tick & sclk_q;
  assign last_bit = (bit_q == 4'd0);
  assign is_read  = (frame_q[9:8] == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      shift_q    <= '0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      shift_q    <= shift_d;
      frame_q    <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CMD;
      S_CMD:     if (bit_end && last_bit)
                   state_d = !is_read ? S_FINISH : ((RD_WAIT > 0) ? S_RDWAIT : S_RDSHIFT);
      S_RDWAIT:  if (bit_end && last_bit) state_d = S_RDSHIFT;
      S_RDSHIFT: if (bit_end && last_bit) state_d = S_FINISH;
      S_FINISH:  if (tick) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d      = div_q;
    bit_d      = bit_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    shift_d    = shift_q;
    frame_d    = frame_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_d = {cmd[9], cmd};
          busy_d  = 1'b1;
          ss_n_d  = 1'b0;
          mosi_d  = cmd[9];
          bit_d   = 4'd10;
          div_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      S_CMD, S_RDWAIT, S_RDSHIFT: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (tick) sclk_d = ~sclk_q;
        // End of a high half: SCLK falls, so this is where MOSI moves and MISO is sampled.
        if (bit_end) begin
          if (state_q == S_RDSHIFT) shift_d = {shift_q[6:0], MISO};
          if (last_bit) begin
            mosi_d = 1'b0;
            bit_d  = (state_q == S_CMD && RD_WAIT > 0) ? WAIT_LAST : 4'd7;
          end else begin
            bit_d = bit_q - 4'd1;
            if (state_q == S_CMD) mosi_d = frame_q[bit_q - 4'd1];
          end
        end
      end
      S_FINISH: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (tick) begin
          ss_n_d = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          if (is_read) begin
            rd_valid_d = 1'b1;
            rd_data_d  = shift_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign SS_n        = ss_n_q;
  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: unit 0 (CLK_DIV=2, RD_WAIT=2) and unit 1 (CLK_DIV=1, RD_WAIT=0),
// each talking to a behavioural slave + RAM model kept in the bench.
module tb_spi_cmd_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s[2], start_s[2], busy_s[2], done_s[2], rd_valid_s[2];
  logic       ss_n_s[2], sclk_s[2], mosi_s[2], miso_s[2];
  logic [9:0] cmd_s[2];
  logic [7:0] rd_data_s[2];
  logic [2:0] dbg_s[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_cmd_master #(.CLK_DIV(g == 0 ? 2 : 1), .RD_WAIT(g == 0 ? 2 : 0)) u_dut (
      .clk(clk), .rst(rst_s[g]), .start(start_s[g]), .cmd(cmd_s[g]),
      .busy(busy_s[g]), .done(done_s[g]), .rd_data(rd_data_s[g]), .rd_valid(rd_valid_s[g]),
      .SS_n(ss_n_s[g]), .SCLK(sclk_s[g]), .MOSI(mosi_s[g]), .MISO(miso_s[g]),
      .dbg_state_o(dbg_s[g])
    );
  end

  int tests = 0;
  int fails = 0;

  // Slave/RAM reference state per unit
  logic [7:0]  m_ram[2][256];
  logic [7:0]  m_waddr[2], m_raddr[2], exp_rd[2];
  logic [10:0] exp_q[$];

  function automatic int cd(input int u); return (u == 0) ? 2 : 1; endfunction
  function automatic int rw(input int u); return (u == 0) ? 2 : 0; endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int u);
    check($sformatf("rst_ss_n%0d", u), 32'(ss_n_s[u]), 32'd1);
    check($sformatf("rst_sclk%0d", u), 32'(sclk_s[u]), 32'd0);
    check($sformatf("rst_mosi%0d", u), 32'(mosi_s[u]), 32'd0);
    check($sformatf("rst_busy%0d", u), 32'(busy_s[u]), 32'd0);
    check($sformatf("rst_done%0d", u), 32'(done_s[u]), 32'd0);
    check($sformatf("rst_rdv%0d", u), 32'(rd_valid_s[u]), 32'd0);
    check($sformatf("rst_rdd%0d", u), 32'(rd_data_s[u]), 32'd0);
    check($sformatf("rst_idle%0d", u), 32'(dbg_s[u]), 32'd0);
  endtask

  // One frame: request at the current negedge, watch the bus until done.
  task automatic run_frame(input int u, input logic [9:0] c, input bit hold, input logic [9:0] cmd_busy);
    int w, low, pulses, d, r;
    logic [10:0] rx, exp_frame;
    logic [7:0] bval;
    bit rd, prev, mosi_bad, done_early;
    d = cd(u); r = rw(u);
    rd = (c[9:8] == 2'b11);
    bval = 8'h00;
    case (c[9:8])
      2'b00: m_waddr[u] = c[7:0];
      2'b01: m_ram[u][m_waddr[u]] = c[7:0];
      2'b10: m_raddr[u] = c[7:0];
      default: begin bval = m_ram[u][m_raddr[u]]; exp_rd[u] = bval; end
    endcase
    exp_q.push_back({c[9], c});
    start_s[u] = 1'b1;
    cmd_s[u] = c;
    w = 0;
    while (w < 20) begin
      @(negedge clk);
      w++;
      if (ss_n_s[u] === 1'b0) break;
    end
    check("accept_latency", 32'(w), 32'd1);
    check("busy_on_accept", 32'(busy_s[u]), 32'd1);
    if (!hold) start_s[u] = 1'b0;
    cmd_s[u] = cmd_busy;
    low = 0; pulses = 0; prev = 1'b0; rx = '0; mosi_bad = 0; done_early = 0;
    while (ss_n_s[u] === 1'b0 && low < 400) begin
      low++;
      if (sclk_s[u] === 1'b1 && !prev) begin
        pulses++;
        if (pulses <= 11) rx = {rx[9:0], mosi_s[u]};
        if (rd && pulses >= 12 + r && pulses <= 19 + r) miso_s[u] = bval[3'(19 + r - pulses)];
      end
      if (pulses >= 11 && sclk_s[u] === 1'b0 && mosi_s[u] !== 1'b0) mosi_bad = 1;
      if (done_s[u] !== 1'b0) done_early = 1;
      prev = (sclk_s[u] === 1'b1);
      @(negedge clk);
    end
    miso_s[u] = 1'b0;
    exp_frame = exp_q.pop_front();
    check("mosi_frame", 32'(rx), 32'(exp_frame));
    check("sclk_pulses", 32'(pulses), rd ? 32'(19 + r) : 32'd11);
    check("ss_low_cycles", 32'(low), rd ? 32'((39 + 2 * r) * d) : 32'(23 * d));
    check("mosi_idle_after_cmd", 32'(mosi_bad), 32'd0);
    check("no_early_done", 32'(done_early), 32'd0);
    check("done_pulse", 32'(done_s[u]), 32'd1);
    check("busy_at_done", 32'(busy_s[u]), 32'd0);
    check("rd_valid", 32'(rd_valid_s[u]), 32'(rd));
    check("rd_data", 32'(rd_data_s[u]), 32'(exp_rd[u]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    for (int u = 0; u < 2; u++) begin
      rst_s[u] = 1'b1; start_s[u] = 1'b0; cmd_s[u] = '0; miso_s[u] = 1'b0;
      m_waddr[u] = '0; m_raddr[u] = '0; exp_rd[u] = '0;
      for (int a = 0; a < 256; a++) m_ram[u][a] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    @(negedge clk);

    // Directed frames on unit 0: write address, then a write/read round trip of A5
    run_frame(0, 10'h03A, 0, 10'h3FF);
    run_frame(0, 10'h1A5, 0, 10'h000);
    run_frame(0, 10'h23A, 0, 10'h155);
    run_frame(0, 10'h300, 0, 10'h0FF);

    // Back-to-back with start held and cmd changed while busy
    run_frame(0, 10'h1AB, 1, 10'h300);
    run_frame(0, 10'h300, 0, 10'h2AA);

    // Reset in the middle of a read frame, start held high during reset
    start_s[0] = 1'b1; cmd_s[0] = 10'h300;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_mid_frame_ss", 32'(ss_n_s[0]), 32'd0);
    rst_s[0] = 1'b1; start_s[0] = 1'b1;
    exp_rd[0] = 8'h00;
    done_seen = 0;
    @(negedge clk);
    check("abort_ss_n", 32'(ss_n_s[0]), 32'd1);
    check("abort_sclk", 32'(sclk_s[0]), 32'd0);
    check("abort_busy", 32'(busy_s[0]), 32'd0);
    check("abort_done", 32'(done_s[0]), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_beats_start", 32'(ss_n_s[0]), 32'd1);
    rst_s[0] = 1'b0; start_s[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done_s[0] !== 1'b0 || ss_n_s[0] !== 1'b1) done_seen++;
    end
    check("no_done_after_abort", 32'(done_seen), 32'd0);
    check("rd_data_after_abort", 32'(rd_data_s[0]), 32'(exp_rd[0]));

    // Unit 1: read FF, then a write must leave rd_data alone
    run_frame(1, 10'h000, 0, 10'h3C3);
    run_frame(1, 10'h1FF, 0, 10'h000);
    run_frame(1, 10'h200, 0, 10'h111);
    run_frame(1, 10'h300, 0, 10'h222);
    run_frame(1, 10'h15C, 0, 10'h333);

    // End-to-end through the slave RAM
    run_frame(0, 10'h010, 0, 10'h3FF);
    run_frame(0, 10'h177, 0, 10'h000);
    run_frame(0, 10'h210, 0, 10'h0AA);
    run_frame(0, 10'h300, 0, 10'h155);

    // Randomised frames on both units
    for (int i = 0; i < 24; i++) begin
      run_frame(i % 2, 10'($urandom_range(0, 1023)), 0, 10'($urandom_range(0, 1023)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
